// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO result registers
// Signed ops run on magnitudes and fix signs in a final cycle, so latency is WIDTH+2 for every op.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   rem, q, d;
  logic [CW-1:0]      count;
  logic               sign_qp, sign_r, dz;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    abs_a     = (op_r[0] && a_r[WIDTH-1]) ? -a_r : a_r;
    abs_b     = (op_r[0] && b_r[WIDTH-1]) ? -b_r : b_r;
    // multiply: {rem,q} is the 2W accumulator, multiplier bits shift out of q
    mul_sum   = {1'b0, rem} + (q[0] ? {1'b0, d} : '0);
    // divide: rem,q[msb] form the W+1 bit partial remainder; the difference always fits W bits
    div_shift = {rem, q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, d};
    div_sub   = div_shift[WIDTH-1:0] - d;
    prod      = {rem, q};
    prod_fix  = sign_qp ? -prod : prod;
    quo_fix   = sign_qp ? -q : q;
    rem_fix   = sign_r ? -rem : rem;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      rem         <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      sign_qp     <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_r  <= op;
              a_r   <= operand_a;
              b_r   <= operand_b;
              state <= PREP;
            end
          end
          PREP: begin
            sign_qp <= op_r[0] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            sign_r  <= op_r[0] & a_r[WIDTH-1];
            dz      <= op_r[1] && (b_r == '0);
            rem     <= '0;
            count   <= '0;
            if (op_r[1]) begin
              q <= abs_a;
              d <= abs_b;
            end else begin
              q <= abs_b;
              d <= abs_a;
            end
            state <= RUN;
          end
          RUN: begin
            if (op_r[1]) begin
              rem <= div_ge ? div_sub : div_shift[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], div_ge};
            end else begin
              rem <= mul_sum[WIDTH:1];
              q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (dz) begin
              hi_out      <= a_r;
              lo_out      <= '1;
              div_by_zero <= 1'b1;
            end else if (op_r[1]) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end else begin
              {hi_out, lo_out} <= prod_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
// Expected HI/LO come from native SV arithmetic, queued at issue and popped on done.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clock, reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   tgt = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'd0: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = '1;
          e.dz = 1'b1;
        end else if (o == 2'd2) begin
          e.lo = a / b;
          e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = '0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  // caller is at a negedge; start is sampled at the following posedge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    if (push) exp_q.push_back(model(o, a, b));
    @(posedge clock);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    check("done_drop", 64'(done), 64'(0));
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", 64'(done_cnt >= target), 64'(1));
  endtask

  always @(negedge clock) begin
    check("dz_qual", 64'(div_by_zero & ~done), 64'(0));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(exp_q.size()), 64'(1));
      end else begin
        e_mon = exp_q.pop_front();
        check("hi", 64'(hi_out), 64'(e_mon.hi));
        check("lo", 64'(lo_out), 64'(e_mon.lo));
        check("dz", 64'(div_by_zero), 64'(e_mon.dz));
        check("latency", 64'(cyc - start_cyc), 64'(LAT));
        last_hi = e_mon.hi;
        last_lo = e_mon.lo;
      end
      done_cnt++;
    end
  end

  initial begin
    int n;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [1:0]   t_op [10] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [W-1:0] t_a  [10] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd7,
                                32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF};
    logic [W-1:0] t_b  [10] = '{32'd5, 32'h8000_0000, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1234_5678, 32'd1};

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_by_zero), 64'(0));
    check("rst_hi", 64'(hi_out), 64'(0));
    check("rst_lo", 64'(lo_out), 64'(0));
    reset = 1'b1;

    @(negedge clock);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("busy_len", 64'(n), 64'(LAT));
    wait_done(++tgt);

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      issue(t_op[i], t_a[i], t_b[i], 1);
      wait_done(++tgt);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(0, 9)) : $urandom;
      @(negedge clock);
      issue(ro, ra, rb, 1);
      wait_done(++tgt);
    end

    // second start mid-RUN must be dropped
    @(negedge clock);
    issue(2'd0, 32'd1234, 32'd5678, 1);
    repeat (10) @(negedge clock);
    op = 2'd2; operand_a = 32'd99; operand_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(++tgt);
    repeat (40) @(negedge clock);
    check("no_queue", 64'(done_cnt), 64'(tgt));

    // back-to-back: second start lands on the done cycle
    @(negedge clock);
    issue(2'd1, 32'hFFFF_FF00, 32'd77, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    issue(2'd3, 32'hFFFF_FF9C, 32'd7, 1);
    tgt += 2;
    wait_done(tgt);

    // flush while RUN count is 10
    @(negedge clock);
    issue(2'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
    repeat (11) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clock);
    check("flush_nodone", 64'(done_cnt), 64'(tgt));
    check("flush_hi", 64'(hi_out), 64'(last_hi));
    check("flush_lo", 64'(lo_out), 64'(last_lo));

    // flush together with start in IDLE
    @(negedge clock);
    op = 2'd0; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clock);
    check("flush_start_nodone", 64'(done_cnt), 64'(tgt));

    // asynchronous reset mid-RUN
    @(negedge clock);
    issue(2'd2, 32'd1000, 32'd3, 0);
    repeat (15) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hi_out), 64'(0));
    check("arst_lo", 64'(lo_out), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    last_hi = '0;
    last_lo = '0;
    @(negedge clock);
    issue(2'd2, 32'd100, 32'd7, 1);
    wait_done(++tgt);

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
